// File: rtl/bp_resolve_queue.sv
// In-order queue of in-flight IF1 branch predictions; resolves the oldest entry
// against the EX outcome, drives the predictor update port and mispredict redirect.
module bp_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [31:0]      push_pc,
  input  logic             push_taken,
  input  logic [31:0]      push_target,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             ext_flush,
  output logic             upd_we,
  output logic             upd_branched,
  output logic [31:0]      upd_pc,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             err_underflow
);

  logic [31:0]      pc_mem     [DEPTH];
  logic             taken_mem  [DEPTH];
  logic [31:0]      target_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             upd_we_q, upd_we_d;
  logic             upd_branched_q, upd_branched_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             err_underflow_q, err_underflow_d;

  logic             pop, push_acc, mispredict_now;
  logic [31:0]      h_pc, h_target;
  logic             h_taken;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign h_pc     = pc_mem[rd_ptr_q];
  assign h_taken  = taken_mem[rd_ptr_q];
  assign h_target = target_mem[rd_ptr_q];

  always_comb begin
    pop            = res_valid && !empty && !ext_flush;
    mispredict_now = pop && ((res_taken != h_taken) || (res_taken && (res_target != h_target)));
    push_acc       = push_valid && !full && !ext_flush && !mispredict_now;

    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    upd_we_d        = pop;
    upd_branched_d  = pop ? res_taken : upd_branched_q;
    upd_pc_d        = pop ? h_pc : upd_pc_q;
    flush_d         = mispredict_now;
    redirect_pc_d   = redirect_pc_q;
    err_underflow_d = err_underflow_q || (res_valid && empty);

    // Both flush sources drop every entry; a mispredict already blocked the push.
    if (ext_flush || mispredict_now) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop);
    end

    if (mispredict_now)
      redirect_pc_d = res_taken ? res_target : (h_pc + 32'd4);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      upd_we_q        <= 1'b0;
      upd_branched_q  <= 1'b0;
      upd_pc_q        <= '0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      upd_we_q        <= upd_we_d;
      upd_branched_q  <= upd_branched_d;
      upd_pc_q        <= upd_pc_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // Entry storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (rst_n && push_acc) begin
      pc_mem[wr_ptr_q]     <= push_pc;
      taken_mem[wr_ptr_q]  <= push_taken;
      target_mem[wr_ptr_q] <= push_target;
    end
  end

  assign upd_we        = upd_we_q;
  assign upd_branched  = upd_branched_q;
  assign upd_pc        = upd_pc_q;
  assign flush         = flush_q;
  assign redirect_pc   = redirect_pc_q;
  assign err_underflow = err_underflow_q;

endmodule
